mag_timer: RTL and testbench
============================

Name: mag_timer

Overview:
- Consumer end of the microwave control S/R pair.
- Holds the magnetron-on latch and runs the BCD mm:ss cook countdown.
- Feeds timer_done back to the control logic.
- Sits between keypad/load logic, logic_control and the display and magnetron drivers.

Parameters:
- TICK_DIV, 100, clock cycles per one-second tick; legal range 2 to 2^16-1.

Ports:
- clk  input  1  system clock, rising edge.
- rstn  input  1  asynchronous active-low reset.
- S  input  1  set request (start) from the control logic.
- R  input  1  reset request (stop/clear/door/done) from the control logic.
- load  input  1  one-cycle strobe: capture load_time.
- load_time  input  16  BCD {min_tens, min_ones, sec_tens, sec_ones}.
- mag_on  output  1  magnetron enable.
- timer_done  output  1  high while the remaining time is 00:00.
- done_pulse  output  1  one-cycle pulse when a running count reaches 00:00.
- time_bcd  output  16  remaining time in the same BCD layout as load_time.

Behaviour:
- Reset values: mag_on=0, time_bcd=16'h0000, timer_done=1, done_pulse=0, prescaler=0, state IDLE.
- All outputs are registered.
- States:
  - IDLE: time is zero, mag off.
  - ARMED: time is nonzero, mag off.
  - RUN: mag on, counting.
- Per-cycle priority: R, then load, then S, then tick.
- R=1 in any state: mag_on clears next cycle and the prescaler clears; time is held. RUN goes to ARMED; IDLE and ARMED stay.
- load=1 with mag_on=0 and R=0: time_bcd <= clamp(load_time) next cycle.
  - Clamp rules: any digit >9 becomes 9; sec_tens >5 becomes 5.
  - Next state is ARMED if the clamped value is nonzero, else IDLE.
  - S is ignored in that cycle.
- load while in RUN is ignored.
- S=1 in ARMED (R=0, load=0): enter RUN; mag_on=1 next cycle; prescaler cleared.
- S in IDLE or RUN has no effect.
- Prescaler in RUN: counts 0..TICK_DIV-1. Each wrap is a tick that decrements time by one second. The first decrement occurs TICK_DIV cycles after mag_on rises.
- BCD decrement uses a borrow chain:
  - sec_ones 0 wraps to 9;
  - sec_tens 0 wraps to 5;
  - min_ones 0 wraps to 9;
  - min_tens decrements.
  - Example: 10:00 becomes 09:59.
- When a decrement yields 00:00:
  - that cycle's update sets mag_on=0, timer_done=1 and done_pulse=1 for exactly one cycle;
  - state goes to IDLE.
- timer_done equals (time_bcd==0), registered together with time_bcd.
- An R tick collision means R and a tick in the same cycle: R wins and no decrement occurs.
- Reset mid-RUN: everything returns to the reset values immediately (asynchronous).

Optional Feature:
- Macro MAG_TIMER_ADD30_EN.
- Defined: an extra input add30 (1 bit, one-cycle strobe) adds 30 s to time_bcd in BCD.
  - Legal in IDLE, ARMED and RUN.
  - Saturates at 99:59.
  - In IDLE the result moves the state to ARMED.
  - add30 and S in the same cycle from IDLE: the add applies and S is ignored.
  - Priority is below load, above S.
- Undefined: no add30 port and no adder logic.

Decomposition:
- Package mag_pkg holds:
  - BCD_DIGIT_W=4 and TIME_W=16;
  - constants SEC_TENS_MAX=5, DIGIT_MAX=9, TIME_MAX=16'h9959;
  - state typedef {IDLE, ARMED, RUN}.
- One sub-module, mag_tick_gen: prescaler with enable and synchronous clear, producing the tick strobe.
- BCD decrement and clamp live in mag_timer.

Test Plan (TICK_DIV=4):
- Reset with rstn=0 -> mag_on=0, time_bcd=0000, timer_done=1, done_pulse=0.
- load 0003, then S pulse:
  - mag_on=1 one cycle after S;
  - time_bcd reads 0002, 0001, 0000 at 4-cycle intervals;
  - done_pulse is one cycle with mag_on=0 and timer_done=1 on the 0000 cycle.
- load 1000, S, one tick -> time_bcd=0959.
- load 0105, S, R after 5 cycles -> mag_on=0, time held at 0104; S again resumes and reaches 0103 exactly 4 cycles after mag_on rises.
- Clamp and blocking:
  - load 9F7A gives 9959;
  - load 0000 stays IDLE, and S then keeps mag_on=0;
  - load during RUN is ignored.
- With MAG_TIMER_ADD30_EN: add30 at 9945 -> 9959; add30 at 0045 -> 0115.

Source files
------------

// File: rtl/mag_pkg.sv
// Shared widths, BCD limits and state encoding for the microwave cook timer.
package mag_pkg;

    localparam int unsigned BCD_DIGIT_W = 4;
    localparam int unsigned TIME_W      = 16;

    localparam logic [BCD_DIGIT_W-1:0] SEC_TENS_MAX = 4'd5;
    localparam logic [BCD_DIGIT_W-1:0] DIGIT_MAX    = 4'd9;
    localparam logic [TIME_W-1:0]      TIME_MAX     = 16'h9959;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        RUN   = 2'd2
    } mag_state_e;

endpackage

// File: rtl/mag_tick_gen.sv
// One-second prescaler: counts 0..TICK_DIV-1 while enabled, strobes tick_c on wrap.
module mag_tick_gen #(
    parameter int unsigned TICK_DIV = 100
) (
    input  logic clk,
    input  logic rstn,
    input  logic en_i,
    input  logic clr_i,
    output logic tick_c
);

    localparam int unsigned CNT_W = 16;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + CNT_W'(1);
        end
    end

    // A clear in the same cycle as the wrap suppresses the tick.
    assign tick_c = en_i && !clr_i && (cnt_q == CNT_LAST);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/mag_timer.sv
// Magnetron latch and BCD mm:ss cook countdown; optional +30 s key under MAG_TIMER_ADD30_EN.
module mag_timer
    import mag_pkg::*;
#(
    parameter int unsigned TICK_DIV = 100
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              S,
    input  logic              R,
`ifdef MAG_TIMER_ADD30_EN
    input  logic              add30,
`endif
    input  logic              load,
    input  logic [TIME_W-1:0] load_time,
    output logic              mag_on,
    output logic              timer_done,
    output logic              done_pulse,
    output logic [TIME_W-1:0] time_bcd
);

    typedef logic [BCD_DIGIT_W-1:0] digit_t;

    function automatic logic [TIME_W-1:0] bcd_clamp(input logic [TIME_W-1:0] t);
        digit_t mt, mo, st, so;
        {mt, mo, st, so} = t;
        if (mt > DIGIT_MAX)    mt = DIGIT_MAX;
        if (mo > DIGIT_MAX)    mo = DIGIT_MAX;
        if (st > SEC_TENS_MAX) st = SEC_TENS_MAX;
        if (so > DIGIT_MAX)    so = DIGIT_MAX;
        return {mt, mo, st, so};
    endfunction

    function automatic logic [TIME_W-1:0] bcd_dec(input logic [TIME_W-1:0] t);
        digit_t mt, mo, st, so;
        {mt, mo, st, so} = t;
        if (so != '0) begin
            so = so - digit_t'(1);
        end else begin
            so = DIGIT_MAX;
            if (st != '0) begin
                st = st - digit_t'(1);
            end else begin
                st = SEC_TENS_MAX;
                if (mo != '0) begin
                    mo = mo - digit_t'(1);
                end else begin
                    mo = DIGIT_MAX;
                    mt = mt - digit_t'(1);
                end
            end
        end
        return {mt, mo, st, so};
    endfunction

`ifdef MAG_TIMER_ADD30_EN
    // Adding 3 to sec_tens carries once it reaches 6; minutes saturate at 99:59.
    function automatic logic [TIME_W-1:0] bcd_add30(input logic [TIME_W-1:0] t);
        digit_t mt, mo, st, so;
        logic   sat;
        {mt, mo, st, so} = t;
        sat = 1'b0;
        if (st >= digit_t'(3)) begin
            st = st - digit_t'(3);
            if (mo == DIGIT_MAX) begin
                mo = '0;
                if (mt == DIGIT_MAX) sat = 1'b1;
                else                 mt = mt + digit_t'(1);
            end else begin
                mo = mo + digit_t'(1);
            end
        end else begin
            st = st + digit_t'(3);
        end
        return sat ? TIME_MAX : {mt, mo, st, so};
    endfunction
`endif

    mag_state_e        state_q, state_d;
    logic              mag_q, mag_d;
    logic [TIME_W-1:0] time_q, time_d;
    logic              done_q, done_d;
    logic              pulse_q, pulse_d;
    logic              presc_clr;
    logic              tick;
    logic [TIME_W-1:0] load_clamped;
    logic [TIME_W-1:0] time_dec;

    assign load_clamped = bcd_clamp(load_time);
    assign time_dec     = bcd_dec(time_q);

    mag_tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_gen (
        .clk    (clk),
        .rstn   (rstn),
        .en_i   (state_q == RUN),
        .clr_i  (presc_clr),
        .tick_c (tick)
    );

    // Priority: R, load (only while the magnetron is off), add30, S, tick.
    always_comb begin
        state_d   = state_q;
        mag_d     = mag_q;
        time_d    = time_q;
        pulse_d   = 1'b0;
        presc_clr = 1'b0;
        if (R) begin
            mag_d     = 1'b0;
            presc_clr = 1'b1;
            if (state_q == RUN) state_d = ARMED;
        end else if (load && !mag_q) begin
            time_d  = load_clamped;
            state_d = (load_clamped != '0) ? ARMED : IDLE;
`ifdef MAG_TIMER_ADD30_EN
        end else if (add30) begin
            time_d = bcd_add30(time_q);
            if (state_q == IDLE) state_d = ARMED;
`endif
        end else if (S && state_q == ARMED) begin
            state_d   = RUN;
            mag_d     = 1'b1;
            presc_clr = 1'b1;
        end else if (tick) begin
            time_d = time_dec;
            if (time_dec == '0) begin
                state_d = IDLE;
                mag_d   = 1'b0;
                pulse_d = 1'b1;
            end
        end
        done_d = (time_d == '0);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
            mag_q   <= 1'b0;
            time_q  <= '0;
            done_q  <= 1'b1;
            pulse_q <= 1'b0;
        end else begin
            state_q <= state_d;
            mag_q   <= mag_d;
            time_q  <= time_d;
            done_q  <= done_d;
            pulse_q <= pulse_d;
        end
    end

    assign mag_on     = mag_q;
    assign timer_done = done_q;
    assign done_pulse = pulse_q;
    assign time_bcd   = time_q;

endmodule

// File: tb/tb_mag_timer.sv
// Directed bench for mag_timer with TICK_DIV=4: load/clamp table plus countdown sequences.
module tb_mag_timer;

    localparam int unsigned TD = 4;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        S = 1'b0;
    logic        R = 1'b0;
    logic        load = 1'b0;
    logic [15:0] load_time = 16'h0000;
`ifdef MAG_TIMER_ADD30_EN
    logic        add30 = 1'b0;
`endif
    logic        mag_on;
    logic        timer_done;
    logic        done_pulse;
    logic [15:0] time_bcd;

    int checks = 0;
    int errors = 0;

    mag_timer #(.TICK_DIV(TD)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .S          (S),
        .R          (R),
`ifdef MAG_TIMER_ADD30_EN
        .add30      (add30),
`endif
        .load       (load),
        .load_time  (load_time),
        .mag_on     (mag_on),
        .timer_done (timer_done),
        .done_pulse (done_pulse),
        .time_bcd   (time_bcd)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] ld;
        logic [15:0] exp_time;
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Advance one rising edge; outputs are then sampled 1 ns after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(input logic [15:0] v);
        load = 1'b1;
        load_time = v;
        step();
        load = 1'b0;
    endtask

    task automatic pulse_s();
        S = 1'b1;
        step();
        S = 1'b0;
    endtask

    task automatic pulse_r();
        R = 1'b1;
        step();
        R = 1'b0;
    endtask

    task automatic run_steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        vecs[0] = '{16'h0003, 16'h0003};
        vecs[1] = '{16'h9F7A, 16'h9959};
        vecs[2] = '{16'h0000, 16'h0000};
        vecs[3] = '{16'h1234, 16'h1234};
        vecs[4] = '{16'h00A0, 16'h0050};
        vecs[5] = '{16'h6789, 16'h6759};
        vecs[6] = '{16'hFFFF, 16'h9959};

        #12;
        chk("rst mag_on", 16'(mag_on), 16'h0);
        chk("rst time", time_bcd, 16'h0000);
        chk("rst timer_done", 16'(timer_done), 16'h1);
        chk("rst done_pulse", 16'(done_pulse), 16'h0);
        @(negedge clk);
        rstn = 1'b1;
        step();

        // Load/clamp table; a nonzero load must arm, zero must leave S inert.
        for (int i = 0; i < 7; i++) begin
            do_load(vecs[i].ld);
            chk($sformatf("load[%0d] time", i), time_bcd, vecs[i].exp_time);
            chk($sformatf("load[%0d] done", i), 16'(timer_done), 16'(vecs[i].exp_time == 16'h0));
            pulse_s();
            chk($sformatf("load[%0d] S mag", i), 16'(mag_on), 16'(vecs[i].exp_time != 16'h0));
            pulse_r();
            chk($sformatf("load[%0d] R mag", i), 16'(mag_on), 16'h0);
            chk($sformatf("load[%0d] held", i), time_bcd, vecs[i].exp_time);
        end

        // 00:03 countdown to done
        do_load(16'h0003);
        pulse_s();
        chk("cd mag rise", 16'(mag_on), 16'h1);
        for (int k = 2; k >= 0; k--) begin
            run_steps(TD - 1);
            chk($sformatf("cd pre %0d", k), time_bcd, 16'(k + 1));
            step();
            chk($sformatf("cd time %0d", k), time_bcd, 16'(k));
        end
        chk("cd done_pulse", 16'(done_pulse), 16'h1);
        chk("cd mag off", 16'(mag_on), 16'h0);
        chk("cd timer_done", 16'(timer_done), 16'h1);
        step();
        chk("cd pulse width", 16'(done_pulse), 16'h0);
        chk("cd stays 0", time_bcd, 16'h0000);

        // 10:00 borrow chain
        do_load(16'h1000);
        pulse_s();
        run_steps(TD);
        chk("borrow 0959", time_bcd, 16'h0959);
        chk("borrow done", 16'(timer_done), 16'h0);
        pulse_r();

        // Stop and resume keeps the time and restarts the prescaler
        do_load(16'h0105);
        pulse_s();
        run_steps(5);
        pulse_r();
        chk("stop mag", 16'(mag_on), 16'h0);
        chk("stop held", time_bcd, 16'h0104);
        run_steps(6);
        chk("stop still held", time_bcd, 16'h0104);
        pulse_s();
        chk("resume mag", 16'(mag_on), 16'h1);
        run_steps(TD - 1);
        chk("resume pre", time_bcd, 16'h0104);
        step();
        chk("resume 0103", time_bcd, 16'h0103);

        // Load during RUN is ignored
        do_load(16'h0042);
        chk("run load ignored", time_bcd, 16'h0103);
        chk("run load mag", 16'(mag_on), 16'h1);

        // R colliding with a tick wins: prescaler is now at 1, tick due after 2 more edges
        run_steps(2);
        pulse_r();
        chk("collide no dec", time_bcd, 16'h0103);
        chk("collide mag", 16'(mag_on), 16'h0);

        // Asynchronous reset mid-RUN
        pulse_s();
        run_steps(2);
        @(negedge clk);
        rstn = 1'b0;
        #1;
        chk("arst mag", 16'(mag_on), 16'h0);
        chk("arst time", time_bcd, 16'h0000);
        chk("arst done", 16'(timer_done), 16'h1);
        @(negedge clk);
        rstn = 1'b1;
        step();
        pulse_s();
        chk("arst idle S", 16'(mag_on), 16'h0);

`ifdef MAG_TIMER_ADD30_EN
        do_load(16'h9945);
        add30 = 1'b1; step(); add30 = 1'b0;
        chk("add30 sat", time_bcd, 16'h9959);
        do_load(16'h0045);
        add30 = 1'b1; step(); add30 = 1'b0;
        chk("add30 carry", time_bcd, 16'h0115);
        do_load(16'h0000);
        add30 = 1'b1; S = 1'b1; step(); add30 = 1'b0; S = 1'b0;
        chk("add30 idle time", time_bcd, 16'h0030);
        chk("add30 idle S ign", 16'(mag_on), 16'h0);
        pulse_s();
        chk("add30 armed", 16'(mag_on), 16'h1);
        pulse_r();
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
